mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multicycle multiply/divide unit for the RV32M extension.
- Sits directly downstream of the ALU control decoder. It consumes the 5-bit control code when that code selects an M-extension operation, alongside the main ALU's operand buses.
- Produces a 32-bit result with a start/busy/done handshake; the multicycle control FSM stalls the processor on oBusy.
- Radix-2 shift-add multiply and restoring divide, with fixed latency for every operation.

Parameters:
- XLEN, 32, operand/result width.
- ITER, XLEN, number of shift/add or shift/subtract iterations.

Ports:
- iCLK  in  1  clock; all state changes on rising edge.
- iRST  in  1  synchronous, active-high reset.
- iStart  in  1  request; sampled only when oBusy=0.
- iControlSignal  in  5  operation code from the ALU control decoder.
- iA  in  XLEN  rs1 operand (multiplicand/dividend).
- iB  in  XLEN  rs2 operand (multiplier/divisor).
- oBusy  out  1  operation in progress; request not accepted.
- oDone  out  1  one-cycle pulse; oResult valid from this cycle.
- oResult  out  XLEN  result; held until next oDone.

Behaviour:
- Op codes: OPMUL=16, OPMULH=17, OPMULHSU=18, OPMULHU=19, OPDIV=20, OPDIVU=21, OPREM=22, OPREMU=23.
- Reset (iRST=1 at edge): state IDLE; oBusy=0, oDone=0, oResult=0; internal registers cleared. Reset wins over every other input, including mid-operation; an aborted operation never pulses oDone.
- States:
  - IDLE: oBusy=0.
  - RUN: oBusy=1, iteration counter 0..ITER-1.
  - FIX: oBusy=1, single cycle; applies sign correction and special cases.
  - DONE: oBusy=0, oDone=1, single cycle.
- Transitions:
  - IDLE/DONE -> RUN: iStart=1 and iControlSignal in 16..23. The same edge latches iA, iB and the op code, and clears the counter.
  - IDLE/DONE, any other case: IDLE/DONE -> IDLE.
  - iStart with a code outside 16..23: ignored; no busy, no done.
  - RUN -> FIX: when counter=ITER-1.
  - FIX -> DONE: unconditional.
- Latency: accept edge at cycle k; oBusy high cycles k+1..k+ITER+1; oDone high in cycle k+ITER+2 (34 for XLEN=32). Latency is fixed for all ops, including special cases.
- Back-to-back: a new iStart is accepted during the DONE cycle; oDone is still pulsed for the finishing op.
- iStart, iA and iB are ignored while oBusy=1. Operands are latched, so input changes during RUN have no effect.
- Signedness:
  - MULH, DIV and REM treat both operands as signed.
  - MULHSU: iA signed, iB unsigned.
  - MULHU, DIVU and REMU: both unsigned.
  - MUL returns the low XLEN bits, identical for any signedness.
  - Magnitudes are computed unsigned; the sign is applied in FIX.
- Multiply: 2*XLEN product register. MUL returns product[XLEN-1:0]; MULH* return product[2XLEN-1:XLEN] after two's-complement negation of the full 2XLEN value when the result sign is negative.
- Divide: quotient takes the sign of iA xor iB; remainder takes the sign of iA.
- Special cases, resolved in FIX:
  - iB=0: DIV/DIVU return all ones; REM/REMU return iA.
  - Signed overflow, iA=0x80000000 with iB=0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
- oResult is registered and updates only on the FIX->DONE edge.

Decomposition:
- Shared parameter package: OPMUL..OPREMU codes, next to the existing OPADD/OPSUB/FUN3*/FUN7* constants. Also the FUN3MUL..FUN3REMU funct3 values, which the ALU control decoder's MULT branch uses to emit these codes.
- State encoding localparams stay inside the module.
- One combinational sub-module, mdu_step, performs a single iteration (conditional add for multiply, trial subtract/restore for divide) on the partial register; it is instantiated once.

Test Plan:
1. OPMUL, iA=7, iB=-3 (0xFFFFFFFD) -> oDone exactly 34 cycles after the accept edge, oResult=0xFFFFFFEB; oBusy high for the 33 cycles between.
2. OPMULH, 0x80000000 × 0x80000000 -> 0x40000000; OPMULHU, 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; OPMULHSU, iA=-1, iB=0xFFFFFFFF -> 0xFFFFFFFF.
3. OPDIV, -7/2 -> 0xFFFFFFFD; OPREM, same operands -> 0xFFFFFFFF; OPDIVU, 100/7 -> 14; OPREMU, same operands -> 2.
4. Divide by zero: OPDIVU 5/0 -> 0xFFFFFFFF; OPREM 5/0 -> 5. Overflow: OPDIV 0x80000000/0xFFFFFFFF -> 0x80000000; OPREM same operands -> 0. All with latency 34.
5. Handshake:
   - iStart pulsed mid-RUN with different operands -> ignored; first result unaffected.
   - iStart in the DONE cycle -> accepted; second oDone 34 cycles later.
   - iStart with code 5'd0 -> oBusy stays 0.
6. Assert iRST at cycle 10 of an OPDIV -> next cycle oBusy=0, oResult=0, no oDone ever; a following OPMUL 3×4 returns 12 normally.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared ALU/MDU encodings: ALU control codes, funct3/funct7 values and M-extension op codes.
// The ALU control decoder's MULT branch maps FUN3MUL..FUN3REMU onto OPMUL..OPREMU.
package mul_div_unit_pkg;

  localparam logic [4:0] OPADD    = 5'd0;
  localparam logic [4:0] OPSUB    = 5'd1;

  localparam logic [2:0] FUN3ADDSUB = 3'b000;
  localparam logic [6:0] FUN7ADD    = 7'b0000000;
  localparam logic [6:0] FUN7SUB    = 7'b0100000;
  localparam logic [6:0] FUN7MULT   = 7'b0000001;

  localparam logic [2:0] FUN3MUL    = 3'b000;
  localparam logic [2:0] FUN3MULH   = 3'b001;
  localparam logic [2:0] FUN3MULHSU = 3'b010;
  localparam logic [2:0] FUN3MULHU  = 3'b011;
  localparam logic [2:0] FUN3DIV    = 3'b100;
  localparam logic [2:0] FUN3DIVU   = 3'b101;
  localparam logic [2:0] FUN3REM    = 3'b110;
  localparam logic [2:0] FUN3REMU   = 3'b111;

  localparam logic [4:0] OPMUL    = 5'd16;
  localparam logic [4:0] OPMULH   = 5'd17;
  localparam logic [4:0] OPMULHSU = 5'd18;
  localparam logic [4:0] OPMULHU  = 5'd19;
  localparam logic [4:0] OPDIV    = 5'd20;
  localparam logic [4:0] OPDIVU   = 5'd21;
  localparam logic [4:0] OPREM    = 5'd22;
  localparam logic [4:0] OPREMU   = 5'd23;

  function automatic logic is_mdu_op(input logic [4:0] code);
    return code[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on the {acc, lo} partial register: shift-add for multiply,
// trial subtract/restore for divide. Purely combinational.
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   sh;
  logic [XLEN-1:0] dsub;
  logic            ge;

  always_comb begin
    sum  = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    sh   = {acc, lo[XLEN-1]};
    ge   = sh >= {1'b0, opnd};
    // When ge holds the difference is below the divisor, so XLEN bits suffice.
    dsub = sh[XLEN-1:0] - opnd;
    if (is_div) begin
      acc_nxt = ge ? dsub : sh[XLEN-1:0];
      lo_nxt  = {lo[XLEN-2:0], ge};
    end else begin
      acc_nxt = sum[XLEN:1];
      lo_nxt  = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// RV32M iterative multiply/divide: unsigned magnitude iterations, sign fix-up in one extra cycle.
// Fixed latency ITER+2 cycles from accept to done; requests are ignored while busy.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = XLEN
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iStart,
  input  logic [4:0]      iControlSignal,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic            oBusy,
  output logic            oDone,
  output logic [XLEN-1:0] oResult
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [4:0]      op;
  logic [XLEN-1:0] acc, lo, opnd;
  logic            sgn, a_neg;

  logic [XLEN-1:0]   acc_nxt, lo_nxt;
  logic              accept, a_sg, b_sg, an, bn, in_div;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  assign oBusy = (state == S_RUN) || (state == S_FIX);
  assign oDone = (state == S_DONE);

  always_comb begin
    accept = iStart && !oBusy && is_mdu_op(iControlSignal);
    in_div = iControlSignal[2];
    a_sg   = (iControlSignal == OPMULH) || (iControlSignal == OPMULHSU) ||
             (iControlSignal == OPDIV)  || (iControlSignal == OPREM);
    b_sg   = (iControlSignal == OPMULH) || (iControlSignal == OPDIV) ||
             (iControlSignal == OPREM);
    an     = a_sg && iA[XLEN-1];
    bn     = b_sg && iB[XLEN-1];
    a_mag  = an ? -iA : iA;
    b_mag  = bn ? -iB : iB;
  end

  mdu_step #(.XLEN(XLEN)) u_step (
    .is_div  (op[2]),
    .acc     (acc),
    .lo      (lo),
    .opnd    (opnd),
    .acc_nxt (acc_nxt),
    .lo_nxt  (lo_nxt)
  );

  // Signed overflow (most-negative / -1) needs no extra handling: the magnitudes
  // give quotient 2^(XLEN-1) with a positive sign and a zero remainder.
  always_comb begin
    prod = sgn ? -{acc, lo} : {acc, lo};
    quo  = (opnd == '0) ? '1 : (sgn ? -lo : lo);
    rem  = a_neg ? -acc : acc;
    case (op)
      OPMUL:                      fix_res = prod[XLEN-1:0];
      OPMULH, OPMULHSU, OPMULHU:  fix_res = prod[2*XLEN-1:XLEN];
      OPDIV, OPDIVU:              fix_res = quo;
      default:                    fix_res = rem;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op      <= '0;
      acc     <= '0;
      lo      <= '0;
      opnd    <= '0;
      sgn     <= 1'b0;
      a_neg   <= 1'b0;
      oResult <= '0;
    end else begin
      case (state)
        S_RUN: begin
          acc <= acc_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= S_FIX;
        end
        S_FIX: begin
          oResult <= fix_res;
          state   <= S_DONE;
        end
        default: begin
          if (accept) begin
            state <= S_RUN;
            cnt   <= '0;
            op    <= iControlSignal;
            acc   <= '0;
            lo    <= in_div ? a_mag : b_mag;
            opnd  <= in_div ? b_mag : a_mag;
            sgn   <= (iControlSignal == OPMUL) ? 1'b0 : (an ^ bn);
            a_neg <= an;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M cases, handshake corners,
// mid-operation reset and randomized ops against an arithmetic reference model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iStart;
  logic [4:0]  iControlSignal;
  logic [31:0] iA, iB;
  logic        oBusy, oDone;
  logic [31:0] oResult;

  int n_cmp = 0;
  int n_bad = 0;

  mul_div_unit #(.XLEN(32), .ITER(32)) dut (
    .iCLK           (iCLK),
    .iRST           (iRST),
    .iStart         (iStart),
    .iControlSignal (iControlSignal),
    .iA             (iA),
    .iB             (iB),
    .oBusy          (oBusy),
    .oDone          (oDone),
    .oResult        (oResult)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RISC-V M semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ua = {32'b0, a};
    longint ub = {32'b0, b};
    logic [63:0] p;
    case (op)
      OPMUL:    begin p = ua * ub; return p[31:0];  end
      OPMULH:   begin p = sa * sb; return p[63:32]; end
      OPMULHSU: begin p = sa * ub; return p[63:32]; end
      OPMULHU:  begin p = ua * ub; return p[63:32]; end
      OPDIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      OPDIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      OPREM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default:  begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge of the done cycle so a
  // following call presents its request during that done cycle.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit glitch, input string tag);
    logic [31:0] exp;
    int n, busy_n;
    bit seen;
    exp = ref_md(op, a, b);
    iStart = 1'b1; iControlSignal = op; iA = a; iB = b;
    @(posedge iCLK);
    #1;
    iStart = 1'b0; iA = $urandom; iB = $urandom;
    n = 0; busy_n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge iCLK);
      n++;
      if (oDone) seen = 1'b1;
      else begin
        if (oBusy) busy_n++;
        if (glitch && n == 5) begin
          iStart = 1'b1; iControlSignal = OPDIVU; iA = $urandom; iB = $urandom;
        end else iStart = 1'b0;
      end
    end
    chk({tag, " latency"}, seen ? n : 0, 34);
    chk({tag, " busy_cycles"}, busy_n, 33);
    chk({tag, " busy_at_done"}, {31'b0, oBusy}, 0);
    chk({tag, " result"}, oResult, exp);
  endtask

  typedef struct { logic [4:0] op; logic [31:0] a; logic [31:0] b; } vec_t;
  vec_t dir [12];

  initial begin
    int dones;
    logic [4:0] rop;
    logic [31:0] ra, rb;

    dir[0]  = '{OPMUL,    32'd7,          32'hFFFF_FFFD};
    dir[1]  = '{OPMULH,   32'h8000_0000,  32'h8000_0000};
    dir[2]  = '{OPMULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
    dir[3]  = '{OPMULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF};
    dir[4]  = '{OPDIV,    32'hFFFF_FFF9,  32'd2};
    dir[5]  = '{OPREM,    32'hFFFF_FFF9,  32'd2};
    dir[6]  = '{OPDIVU,   32'd100,        32'd7};
    dir[7]  = '{OPREMU,   32'd100,        32'd7};
    dir[8]  = '{OPDIVU,   32'd5,          32'd0};
    dir[9]  = '{OPREM,    32'd5,          32'd0};
    dir[10] = '{OPDIV,    32'h8000_0000,  32'hFFFF_FFFF};
    dir[11] = '{OPREM,    32'h8000_0000,  32'hFFFF_FFFF};

    iRST = 1'b1; iStart = 1'b0; iControlSignal = '0; iA = '0; iB = '0;
    repeat (2) @(negedge iCLK);
    chk("reset busy", {31'b0, oBusy}, 0);
    chk("reset done", {31'b0, oDone}, 0);
    chk("reset result", oResult, 0);
    iRST = 1'b0;
    @(negedge iCLK);

    // Consecutive calls are back-to-back: each new request lands in the done cycle.
    foreach (dir[i]) run_op(dir[i].op, dir[i].a, dir[i].b, 1'b0, $sformatf("dir%0d", i));

    @(negedge iCLK);
    run_op(OPMUL, 32'd123, 32'd456, 1'b1, "midrun_start");

    @(negedge iCLK);
    iStart = 1'b1; iControlSignal = 5'd0; iA = 32'd9; iB = 32'd9;
    @(negedge iCLK);
    iStart = 1'b0;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      chk("badcode busy", {31'b0, oBusy}, 0);
      if (oDone) dones++;
      @(negedge iCLK);
    end
    chk("badcode done", dones, 0);

    for (int i = 0; i < 60; i++) begin
      rop = OPMUL + 5'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) @(negedge iCLK);
      run_op(rop, ra, rb, 1'b0, $sformatf("rnd%0d", i));
    end

    run_op(OPDIVU, 32'd100, 32'd7, 1'b0, "pre_reset");
    @(negedge iCLK);
    iStart = 1'b1; iControlSignal = OPDIV; iA = 32'd1000; iB = 32'd3;
    @(posedge iCLK);
    #1;
    iStart = 1'b0;
    repeat (10) @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    chk("abort busy", {31'b0, oBusy}, 0);
    chk("abort result", oResult, 0);
    iRST = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (oDone) dones++;
      @(negedge iCLK);
    end
    chk("abort no_done", dones, 0);
    run_op(OPMUL, 32'd3, 32'd4, 1'b0, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
